// File: rtl/uart_arb_pkg.sv
// Shared types and default parameter values for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_MAX_BURST      = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first valid request after rr_ptr_i, wrapping.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               any_o
);

    int unsigned idx;

    // Offset 1 first so the last owner is checked last.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(rr_ptr_i) + off) % NUM_REQ;
            if (!any_o && req_i[IDX_W'(idx)]) begin
                winner_o[IDX_W'(idx)] = 1'b1;
                any_o                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional stall timeout on the granted requester: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned MAX_BURST      = DEF_MAX_BURST,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d, beat_inc;
    logic [IDX_W-1:0]    gidx;
    logic [NUM_REQ-1:0]  pick_win;
    logic                pick_any;
    logic                hs, last_g, cap_hit, drop_grant;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0]  stall_q, stall_d, stall_inc;
    logic                valid_g;
    assign valid_g   = |(req_valid & grant_q);
    assign stall_inc = stall_q + STALL_W'(1);
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (pick_win),
        .any_o    (pick_any)
    );

    assign grant = grant_q;
    assign busy  = (state_q == ARB_XFER);

    // Passthrough of the owner's stream; an idle arbiter has an all-zero grant so everything reads 0.
    always_comb begin
        tx_data = '0;
        gidx    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) begin
                tx_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                gidx    = IDX_W'(i);
            end
        end
        tx_valid  = ena & |(grant_q & req_valid);
        req_ready = ena ? (grant_q & {NUM_REQ{tx_ready}}) : '0;
    end

    assign hs       = tx_valid & tx_ready;
    assign last_g   = |(req_last & grant_q);
    assign beat_inc = beat_q + BEAT_W'(1);
    assign cap_hit  = (beat_inc == BEAT_W'(MAX_BURST));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_d     = beat_q;
        drop_grant = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        stall_d    = stall_q;
`endif
        if (ena) begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_d = pick_win;
                        beat_d  = '0;
                        state_d = ARB_XFER;
`ifdef UART_ARB_TIMEOUT_EN
                        stall_d = '0;
`endif
                    end
                end
                ARB_XFER: begin
                    if (hs) begin
                        beat_d = beat_inc;
                    end
                    if (hs && (last_g || cap_hit)) begin
                        drop_grant = 1'b1;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // Only an absent byte counts as a stall; UART backpressure does not.
                    if (hs || valid_g) begin
                        stall_d = '0;
                    end else if (stall_inc == STALL_W'(TIMEOUT_CYCLES)) begin
                        drop_grant = 1'b1;
                    end else begin
                        stall_d = stall_inc;
                    end
`endif
                    if (drop_grant) begin
                        rr_ptr_d = gidx;
                        grant_d  = '0;
                        state_d  = ARB_IDLE;
                    end
                end
                default: begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            beat_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q  <= stall_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: streaming byte sources plus a UART-side capture log.
module tb_uart_tx_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              ena;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [NR-1:0]     grant;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // Sources: append-only byte streams; ptr is advanced only by the monitor.
    logic [7:0] mem   [NR][64];
    bit         lastm [NR][64];
    int         len   [NR];
    int         ptr   [NR] = '{default: 0};
    bit         vmask [NR];
    bit         pend  [NR] = '{default: 1'b0};

    int         cyc = 0;
    int         rx_n = 0;
    logic [7:0] rx_d [128];
    int         rx_s [128];
    int         rx_c [128];

    uart_tx_arbiter #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .MAX_BURST      (MB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = vmask[i] && (ptr[i] < len[i]);
            req_data[i*DW +: DW]  = mem[i][ptr[i][5:0]];
            req_last[i]           = lastm[i][ptr[i][5:0]];
        end
    end

    function automatic int gidx_of(input logic [NR-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Sample at negedge (inputs stable), commit pointer advances just after the posedge.
    always begin
        @(negedge clk);
        if (!reset) begin
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) pend[i] = 1'b1;
            if (tx_valid && tx_ready) begin
                if (rx_n < 128) begin
                    rx_d[rx_n] = tx_data;
                    rx_s[rx_n] = gidx_of(grant);
                    rx_c[rx_n] = cyc;
                end
                rx_n++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (pend[i]) begin
                ptr[i]++;
                pend[i] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int i, input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            mem[i][len[i]]   = first + 8'(k);
            lastm[i][len[i]] = (k == n - 1);
            len[i]++;
        end
    endtask

    function automatic bit drained();
        for (int i = 0; i < NR; i++)
            if (vmask[i] && ptr[i] < len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            done = !busy && drained();
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic chk_rx(input string tag, input int k, input int src, input logic [7:0] d);
        check({tag, "_src"}, 32'(rx_s[k]), 32'(src));
        check({tag, "_dat"}, 32'(rx_d[k]), 32'(d));
    endtask

    int b;

    initial begin
        reset    = 1'b1;
        ena      = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            vmask[i] = 1'b1;
            len[i]   = 0;
        end
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_txv", 32'(tx_valid), 32'd0);
        check("rst_rdy", 32'(req_ready), 32'd0);
        check("rst_txd", 32'(tx_data), 32'd0);

        // Single requester 2, three-byte message
        b = rx_n;
        load(2, 8'h41, 3);
        #1;
        check("t1_pre_grant", 32'(grant), 32'd0);
        step();
        check("t1_grant", 32'(grant), 32'b0100);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_txv", 32'(tx_valid), 32'd1);
        check("t1_txd", 32'(tx_data), 32'h41);
        check("t1_rdy", 32'(req_ready), 32'b0100);
        drain("t1_drain");
        check("t1_cnt", 32'(rx_n - b), 32'd3);
        chk_rx("t1_b0", b, 2, 8'h41);
        chk_rx("t1_b1", b + 1, 2, 8'h42);
        chk_rx("t1_b2", b + 2, 2, 8'h43);
        check("t1_back2back", 32'(rx_c[b+2] - rx_c[b]), 32'd2);
        check("t1_idle_grant", 32'(grant), 32'd0);

        // Contention: all four, requester 0 has a second message
        do_reset();
        b = rx_n;
        load(0, 8'hA0, 1);
        load(1, 8'hA1, 1);
        load(2, 8'hA2, 1);
        load(3, 8'hA3, 1);
        load(0, 8'hB0, 1);
        drain("t2_drain");
        check("t2_cnt", 32'(rx_n - b), 32'd5);
        chk_rx("t2_0", b, 0, 8'hA0);
        chk_rx("t2_1", b + 1, 1, 8'hA1);
        chk_rx("t2_2", b + 2, 2, 8'hA2);
        chk_rx("t2_3", b + 3, 3, 8'hA3);
        chk_rx("t2_4", b + 4, 0, 8'hB0);
        check("t2_bubble", 32'(rx_c[b+1] - rx_c[b]), 32'd2);

        // Burst cap of 4: requester 1 six bytes, requester 3 pending
        do_reset();
        b = rx_n;
        load(1, 8'h10, 6);
        load(3, 8'h30, 1);
        drain("t3_drain");
        check("t3_cnt", 32'(rx_n - b), 32'd7);
        chk_rx("t3_0", b, 1, 8'h10);
        chk_rx("t3_3", b + 3, 1, 8'h13);
        chk_rx("t3_4", b + 4, 3, 8'h30);
        chk_rx("t3_5", b + 5, 1, 8'h14);
        chk_rx("t3_6", b + 6, 1, 8'h15);

        // Backpressure mid-message
        do_reset();
        b = rx_n;
        load(0, 8'h50, 5);
        step();
        step();
        tx_ready = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("t4_rdy", 32'(req_ready), 32'd0);
            check("t4_txd", 32'(tx_data), 32'h51);
            step();
        end
        check("t4_held_cnt", 32'(rx_n - b), 32'd1);
        tx_ready = 1'b1;
        drain("t4_drain");
        check("t4_cnt", 32'(rx_n - b), 32'd5);
        for (int k = 0; k < 5; k++) chk_rx("t4_b", b + k, 0, 8'h50 + 8'(k));

        // Enable low mid-message
        do_reset();
        b = rx_n;
        load(1, 8'h60, 4);
        step();
        step();
        ena = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t5_txv", 32'(tx_valid), 32'd0);
            check("t5_rdy", 32'(req_ready), 32'd0);
            check("t5_grant", 32'(grant), 32'b0010);
            step();
        end
        check("t5_held_cnt", 32'(rx_n - b), 32'd1);
        ena = 1'b1;
        drain("t5_drain");
        check("t5_cnt", 32'(rx_n - b), 32'd4);
        chk_rx("t5_last", b + 3, 1, 8'h63);

        // Reset mid-message truncates; requester 0 wins first afterwards
        do_reset();
        b = rx_n;
        load(2, 8'h70, 5);
        step();
        step();
        reset = 1'b1;
        step();
        check("t6_grant", 32'(grant), 32'd0);
        check("t6_txv", 32'(tx_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        len[2] = ptr[2];
        reset = 1'b0;
        load(0, 8'hC0, 1);
        load(2, 8'hC2, 1);
        step();
        check("t6_first_grant", 32'(grant), 32'b0001);
        drain("t6_drain");
        check("t6_cnt", 32'(rx_n - b), 32'd3);
        chk_rx("t6_0", b, 2, 8'h70);
        chk_rx("t6_1", b + 1, 0, 8'hC0);
        chk_rx("t6_2", b + 2, 2, 8'hC2);

`ifdef UART_ARB_TIMEOUT_EN
        // Granted requester goes silent for TO cycles
        do_reset();
        b = rx_n;
        load(0, 8'h80, 3);
        load(1, 8'h90, 1);
        step();
        check("t7_grant0", 32'(grant), 32'b0001);
        vmask[0] = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("t7_still", 32'(grant), 32'b0001);
        step();
        check("t7_released", 32'(grant), 32'd0);
        vmask[0] = 1'b1;
        step();
        check("t7_next", 32'(grant), 32'b0010);
        drain("t7_drain");
        check("t7_cnt", 32'(rx_n - b), 32'd4);
        chk_rx("t7_0", b, 1, 8'h90);
        chk_rx("t7_1", b + 1, 0, 8'h80);
        chk_rx("t7_3", b + 3, 0, 8'h82);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among `NUM_REQ` independent byte-stream requesters, using round-robin arbitration with message locking. A requester holds the grant until it flags the last byte of a message, or until a burst cap forces release. The block sits between on-chip message sources (shift-register dumpers, status reporters, echo path) and the `uart` instance's `tx_data`/`tx_valid`/`tx_ready` port.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width forwarded to the UART.
- `NUM_REQ`, 4, number of requesters (2..8).
- `MAX_BURST`, 16, maximum beats per grant before forced release (≥1).
- `TIMEOUT_CYCLES`, 1024, stall limit used only when `UART_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ena`  in  1  block enable; low freezes all state.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_valid`  in  `NUM_REQ`  requester byte valid.
- `req_last`  in  `NUM_REQ`  marks the final byte of a message; sampled only with a handshake.
- `req_ready`  out  `NUM_REQ`  byte accepted by the arbiter.
- `tx_data`  out  `DATA_WIDTH`  byte to the UART.
- `tx_valid`  out  1  byte valid to the UART.
- `tx_ready`  in  1  UART can accept a byte.
- `grant`  out  `NUM_REQ`  one-hot owner of the channel; all-zero when idle.
- `busy`  out  1  high in ARB_XFER.

## Operation
- FSM states:
  - ARB_IDLE: grant = 0. If `ena` and any `req_valid`, pick a winner, load it into `grant`, clear the beat counter, and go to ARB_XFER.
  - ARB_XFER: the granted requester's signals pass through. On a handshake with `req_last` set, or when the beat counter reaches `MAX_BURST`: update `rr_ptr` to the granted index, clear `grant`, and go to ARB_IDLE.
- Round-robin pick: search starts at index `rr_ptr+1` and wraps modulo `NUM_REQ`; the first valid requester wins. Every requester is served within `NUM_REQ` grants.
- Passthrough in ARB_XFER (combinational):
  - `tx_data` = granted slice of `req_data`.
  - `tx_valid` = granted `req_valid`.
  - `req_ready[g]` = `tx_ready`; all other `req_ready` bits are 0.
- Handshake: `tx_valid & tx_ready` in the same cycle; each handshake increments the beat counter.
- Beat counter width: `$clog2(MAX_BURST+1)`. It is never allowed to exceed `MAX_BURST`.
- Forced release on burst cap: the message is not terminated. The requester re-arbitrates and continues later; bytes are never dropped.
- Simultaneous last byte and burst cap: a single release.
- `ena` low: FSM, counters, and grant hold. `tx_valid` and all `req_ready` are forced to 0, so no handshake can occur.
- Reset mid-message: the grant is dropped at the next edge and the partial message is truncated. The UART only ever sees whole bytes.
- Reset values: `grant`=0, `busy`=0, `tx_valid`=0, `req_ready`=0, `tx_data`=0, `rr_ptr`=`NUM_REQ-1` (so requester 0 wins first), beat counter = 0, state ARB_IDLE.

## Timing
- `req_valid` first seen in ARB_IDLE at cycle N: `grant`/`busy` high at N+1, and `tx_valid` can assert at N+1.
- Release handshake at cycle M: ARB_IDLE at M+1, next grant at M+2. Minimum inter-message bubble is one idle cycle.
- Throughput inside a grant: one byte per cycle when the UART is always ready.
- `grant`, `busy`, and state are registered. `tx_*` and `req_ready` are combinational from registered `grant` and the inputs.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A stall counter runs in ARB_XFER and clears on each handshake.
  - If the granted `req_valid` stays low for `TIMEOUT_CYCLES` consecutive enabled cycles, the grant is released exactly as on a last byte.
  - Stalls caused only by `tx_ready` low do not count.
- `UART_ARB_TIMEOUT_EN` undefined: no stall counter. The grant is held indefinitely until last byte or burst cap.

## Structure
- Package `uart_arb_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_XFER}.
  - Default parameter constants.
- Sub-module `uart_rr_pick`: combinational round-robin selector. Inputs are the request vector and `rr_ptr`; outputs are a one-hot winner and an `any` flag. The rest of the logic lives in `uart_tx_arbiter`.

## Test plan
- Single requester: req 2 sends 0x41, 0x42, 0x43 (last on 0x43), UART always ready → `grant`=4'b0100 one cycle after valid; UART receives 0x41, 0x42, 0x43 in three consecutive cycles; idle afterwards.
- Contention: all four requesters send 1-byte messages from reset → grant order 0, 1, 2, 3; then 0 again if still valid.
- Burst cap (`MAX_BURST`=4): req 1 sends 6 bytes with req 3 pending → 4 bytes from req 1, then req 3's message, then req 1's remaining 2 bytes.
- Backpressure: `tx_ready` low for 10 cycles mid-message → `req_ready` low, data held, no byte lost or duplicated.
- `ena` and reset: `ena` low for 5 cycles mid-message → no handshakes, grant unchanged. Reset asserted mid-message → next cycle `grant`=0, `tx_valid`=0; first post-reset grant goes to requester 0.
- Timeout (`UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): granted requester drops valid for 8 cycles → grant released; another pending requester is granted 2 cycles later.
